// File: rtl/hc_sr04_s00_axi.sv
// AXI4-Lite slave with four byte-strobed registers exported to the HC-SR04 sensor core.
// Independent write and read FSMs; ready strobes assert in the accept cycle itself.
module hc_sr04_s00_axi #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg3
);

    localparam int NumLanes = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic {WIdle, WResp} w_state_t;
    typedef enum logic {RIdle, RData} r_state_t;

    w_state_t                              w_state;
    r_state_t                              r_state;
    logic [3:0][C_S_AXI_DATA_WIDTH-1:0]    regs;
    logic [C_S_AXI_DATA_WIDTH-1:0]         rdata;
    logic [1:0]                            waddr;
    logic [1:0]                            raddr;
    logic                                  wr_acc;
    logic                                  rd_acc;
    logic                                  unused_in;

    // Reset gates the accept strobes so readys stay low while reset is held.
    assign wr_acc = S_AXI_ARESETN && (w_state == WIdle) && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_acc = S_AXI_ARESETN && (r_state == RIdle) && S_AXI_ARVALID;
    assign waddr  = S_AXI_AWADDR[3:2];
    assign raddr  = S_AXI_ARADDR[3:2];

    assign S_AXI_AWREADY = wr_acc;
    assign S_AXI_WREADY  = wr_acc;
    assign S_AXI_BVALID  = (w_state == WResp);
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = rd_acc;
    assign S_AXI_RVALID  = (r_state == RData);
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RDATA   = rdata;

    assign slv_reg0 = regs[0];
    assign slv_reg1 = regs[1];
    assign slv_reg2 = regs[2];
    assign slv_reg3 = regs[3];

    assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state <= WIdle;
            regs    <= '0;
        end else begin
            case (w_state)
                WIdle: begin
                    if (wr_acc) begin
                        for (int b = 0; b < NumLanes; b++) begin
                            if (S_AXI_WSTRB[b]) begin
                                regs[waddr][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
                            end
                        end
                        w_state <= WResp;
                    end
                end
                WResp: begin
                    if (S_AXI_BREADY) begin
                        w_state <= WIdle;
                    end
                end
                default: w_state <= WIdle;
            endcase
        end
    end

    // Reads sample regs before this edge's write lands, so a colliding read sees the old value.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= RIdle;
            rdata   <= '0;
        end else begin
            case (r_state)
                RIdle: begin
                    if (rd_acc) begin
                        rdata   <= regs[raddr];
                        r_state <= RData;
                    end
                end
                RData: begin
                    if (S_AXI_RREADY) begin
                        r_state <= RIdle;
                    end
                end
                default: r_state <= RIdle;
            endcase
        end
    end

endmodule

// File: doc/hc_sr04_s00_axi.md
HC_SR04_S00_AXI -- requirements
Module: hc_sr04_s00_axi

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, giving the AXI data bus width in bits.
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, giving the AXI address width in bits.
REQ-003 The block SHALL have port S_AXI_ACLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port S_AXI_ARESETN, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have S_AXI_AWADDR (in, ADDR_WIDTH), S_AXI_AWPROT (in, 3), S_AXI_AWVALID (in, 1) and S_AXI_AWREADY (out, 1): the write address channel.
REQ-006 The block SHALL have S_AXI_WDATA (in, DATA_WIDTH), S_AXI_WSTRB (in, DATA_WIDTH/8), S_AXI_WVALID (in, 1) and S_AXI_WREADY (out, 1): the write data channel.
REQ-007 The block SHALL have S_AXI_BRESP (out, 2), S_AXI_BVALID (out, 1) and S_AXI_BREADY (in, 1): the write response channel.
REQ-008 The block SHALL have S_AXI_ARADDR (in, ADDR_WIDTH), S_AXI_ARPROT (in, 3), S_AXI_ARVALID (in, 1) and S_AXI_ARREADY (out, 1): the read address channel.
REQ-009 The block SHALL have S_AXI_RDATA (out, DATA_WIDTH), S_AXI_RRESP (out, 2), S_AXI_RVALID (out, 1) and S_AXI_RREADY (in, 1): the read data channel.
REQ-010 The block SHALL have ports slv_reg0..slv_reg3, each output, DATA_WIDTH bits: the current register contents, exported to the sensor core.

Function
REQ-011 The block SHALL implement four read/write registers, reg0..reg3, at byte offsets 0x0, 0x4, 0x8 and 0xC, decoded from address bits [3:2]; address bits [1:0] and AWPROT/ARPROT SHALL be ignored.
REQ-012 Write acceptance SHALL happen only in a cycle where AWVALID=1, WVALID=1, AWREADY=0 and BVALID=0 (write FSM W_IDLE).
- In that cycle AWREADY and WREADY SHALL be driven 1, for exactly one cycle.
REQ-013 On write acceptance, each byte lane n with WSTRB[n]=1 SHALL be updated in the addressed register at the same edge; lanes with WSTRB[n]=0 SHALL be left unchanged.
REQ-014 BVALID SHALL rise the cycle after acceptance, with BRESP=2'b00.
- BVALID SHALL stay high until the cycle where BREADY=1, then fall (write FSM W_RESP -> W_IDLE).
- No new write SHALL be accepted while BVALID=1.
REQ-015 If only one of AWVALID or WVALID is high, the block SHALL hold AWREADY=WREADY=0 and wait; it SHALL never accept an address without its data.
REQ-016 Read acceptance SHALL happen only in a cycle where ARVALID=1, ARREADY=0 and RVALID=0 (read FSM R_IDLE).
- In that cycle ARREADY SHALL be driven 1, for exactly one cycle.
- The addressed register SHALL be latched into RDATA at that edge.
REQ-017 RVALID SHALL rise the cycle after read acceptance, with RRESP=2'b00.
- RVALID and RDATA SHALL be held stable until RREADY=1, then RVALID SHALL fall (R_DATA -> R_IDLE).
REQ-018 Read and write FSMs SHALL be independent and may both accept in the same cycle.
- Same-cycle read and write to the same register: the read SHALL return the pre-write value.
REQ-019 Back-to-back throughput SHALL be one transaction per two cycles per channel when BREADY or RREADY is held high.
REQ-020 slv_regN SHALL reflect the register value from the edge after the write, with no extra latency.

Reset
REQ-021 While S_AXI_ARESETN=0, asynchronously, all of the following SHALL be 0: AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA, reg0..reg3 and slv_reg0..3.
- Both FSMs SHALL return to idle.
REQ-022 Reset asserted mid-transaction SHALL abort that transaction with no response issued.
- After release, the first cycle with valid inputs SHALL accept normally.

Verification
REQ-023 Writes 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, WSTRB=0xF, then reads of the same addresses -> RDATA 0x1, 0x2, 0x3, 0x4; all BRESP/RRESP=OKAY.
REQ-024 Write 0xAABBCCDD to 0x4, then write 0x11223344 with WSTRB=0x5 -> read returns 0xAA22CC44.
REQ-025 AWVALID held 5 cycles before WVALID rises -> AWREADY=0 until WVALID=1; a single accept follows; BVALID rises one cycle later.
REQ-026 BREADY held low 4 cycles with a second write pending -> BVALID stays high, no second AWREADY; second write accepted the cycle after the BREADY handshake.
REQ-027 Same-cycle write 0x55 and read of 0x8 (old value 0x3) -> RDATA=0x3; a subsequent read returns 0x55.
REQ-028 Reset asserted while RVALID=1 awaits RREADY -> RVALID=0 immediately and all registers read 0x0 after release.
